// File: rtl/mcp_sender.sv
// -----------------------------------------------------------------------------
// mcp_sender
// Source side of a multi-cycle-path (MCP) clock-domain crossing. A word is
// accepted from the source, launched on a registered bus with a level
// request (bus_enable), and released once the destination acknowledges through
// a four-phase handshake. If no acknowledge arrives within TIMEOUT cycles the
// request is withdrawn and a sticky timeout_err flag is raised.
//
// Ports:
//   clk          source-domain clock, all state changes on the rising edge
//   rst          asynchronous active-high reset
//   src_data     word to transfer, sampled only on the accept edge
//   src_valid    source offers src_data
//   src_ready    sender can accept a word this cycle
//   ack_sync     destination acknowledge, already synchronized into clk
//   Unsync_bus   registered data bus to destination, stable while bus_enable
//   bus_enable   registered level request to destination
//   busy         high whenever the FSM is not idle
//   err_clr      clears timeout_err
//   timeout_err  sticky flag: a request timed out
//   state_dbg    current FSM state (IDLE=0, REQ=1, ACK=2) for observation
//
// Handshake semantics: a word moves on a rising edge where src_valid and
// src_ready are both high. src_ready never depends on src_valid, so the
// source may hold src_valid high indefinitely; words offered while src_ready
// is low are simply not taken and nothing is queued.
// -----------------------------------------------------------------------------
module mcp_sender #(
  parameter int BUS_WIDTH = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] src_data,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic                 ack_sync,
  output logic [BUS_WIDTH-1:0] Unsync_bus,
  output logic                 bus_enable,
  output logic                 busy,
  input  logic                 err_clr,
  output logic                 timeout_err,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  // A zero-width counter is illegal, so TIMEOUT=0 (timeout disabled) keeps a
  // one-bit counter that is never compared against anything.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit TIMEOUT_ON = (TIMEOUT > 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          timeout_hit;

  // Stale ack in IDLE blocks acceptance so a new request cannot be paired
  // with the tail of the previous handshake.
  assign src_ready = (state == S_IDLE) && !ack_sync;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;
  assign accept    = src_valid && src_ready;

  // Ack takes priority over the timeout when both land in the same cycle.
  assign timeout_hit = TIMEOUT_ON && (state == S_REQ) && !ack_sync && (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      Unsync_bus  <= '0;
      bus_enable  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            Unsync_bus <= src_data;
            bus_enable <= 1'b1;
            cnt        <= '0;
            state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_sync) begin
            bus_enable <= 1'b0;
            state      <= S_ACK;
          end else if (timeout_hit) begin
            bus_enable <= 1'b0;
            state      <= S_ACK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ACK: begin
          // Wait for the destination to drop its ack (or for a timed-out
          // request, for any late ack to clear) before going idle.
          if (!ack_sync) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state      <= S_IDLE;
          bus_enable <= 1'b0;
        end
      endcase

      // Setting the error wins over a simultaneous clear.
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end else if (err_clr) begin
        timeout_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcp_sender.sv
// -----------------------------------------------------------------------------
// tb_mcp_sender
// Self-checking bench for mcp_sender (BUS_WIDTH=8, TIMEOUT=4). Directed
// scenarios cover the basic transfer, data hold, timeout, ack/timeout
// collision, set/clear collision, stale ack and asynchronous reset; a random
// phase then drives a loosely behaved destination. Every cycle is checked
// against a transaction-level model of the sender.
// -----------------------------------------------------------------------------
module tb_mcp_sender;

  localparam int W  = 8;
  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] src_data = '0;
  logic         src_valid = 1'b0;
  logic         src_ready;
  logic         ack_sync = 1'b0;
  logic [W-1:0] Unsync_bus;
  logic         bus_enable;
  logic         busy;
  logic         err_clr = 1'b0;
  logic         timeout_err;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  mcp_sender #(.BUS_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .ack_sync    (ack_sync),
    .Unsync_bus  (Unsync_bus),
    .bus_enable  (bus_enable),
    .busy        (busy),
    .err_clr     (err_clr),
    .timeout_err (timeout_err),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];   // words expected to appear on the bus, in order
  int n_launched = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A transfer is either absent, "requesting" (request raised, waiting for
  // ack, m_wait cycles elapsed) or "draining" (request dropped, waiting for
  // the ack to fall).
  typedef enum int {P_NONE, P_REQUESTING, P_DRAINING} phase_t;
  phase_t       m_phase;
  int           m_wait;
  logic [W-1:0] m_bus;
  logic         m_en;
  logic         m_err;

  function automatic void model_reset();
    m_phase = P_NONE;
    m_wait  = 0;
    m_bus   = '0;
    m_en    = 1'b0;
    m_err   = 1'b0;
  endfunction

  // Applies one rising edge with the given sampled inputs.
  function automatic void model_edge(input logic v, input logic [W-1:0] d,
                                     input logic a, input logic c);
    logic set_err = 1'b0;
    case (m_phase)
      P_NONE: if (v && !a) begin
        m_bus = d; m_en = 1'b1; m_wait = 0; m_phase = P_REQUESTING;
        exp_q.push_back(d);
      end
      P_REQUESTING: begin
        if (a) begin
          m_en = 1'b0; m_phase = P_DRAINING;
        end else begin
          m_wait++;
          // Request has now been up for TO full cycles with no ack.
          if (TO > 0 && m_wait == TO) begin
            m_en = 1'b0; m_phase = P_DRAINING; set_err = 1'b1;
          end
        end
      end
      P_DRAINING: if (!a) m_phase = P_NONE;
      default: ;
    endcase
    if (set_err) m_err = 1'b1;
    else if (c)  m_err = 1'b0;
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge: drive inputs, check the combinational
  // ready, clock one edge, check the registered outputs.
  logic prev_en = 1'b0;

  task automatic step(input logic v, input logic [W-1:0] d, input logic a, input logic c);
    src_valid = v; src_data = d; ack_sync = a; err_clr = c;
    #1;
    check("src_ready", src_ready, (m_phase == P_NONE) && !a);
    @(posedge clk);
    model_edge(v, d, a, c);
    #1;
    check("bus_enable", bus_enable, m_en);
    check("Unsync_bus", Unsync_bus, m_bus);
    check("busy", busy, m_phase != P_NONE);
    check("timeout_err", timeout_err, m_err);
    check("state_dbg_idle", state_dbg == 2'd0, m_phase == P_NONE);
    // Each new request rise must carry the next queued word.
    if (bus_enable && !prev_en) begin
      if (exp_q.size() == 0) check("unexpected_launch", 1, 0);
      else check("launch_word", Unsync_bus, exp_q.pop_front());
      n_launched++;
    end
    prev_en = bus_enable;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic a;
    model_reset();
    #1;
    check("rst_bus_enable", bus_enable, 0);
    check("rst_Unsync_bus", Unsync_bus, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic transfer and hold of the bus while src_data changes.
    step(1, 8'hA5, 0, 0);
    check("basic_bus", Unsync_bus, 8'hA5);
    check("basic_en", bus_enable, 1);
    step(1, 8'h3C, 0, 0);
    step(0, 8'h3C, 0, 0);
    step(1, 8'h3C, 1, 0);                 // ack arrives, request drops
    check("basic_en_fall", bus_enable, 0);
    step(1, 8'h3C, 1, 0);
    check("hold_bus", Unsync_bus, 8'hA5);
    step(0, 8'h3C, 0, 0);                 // ack falls, back to idle
    check("basic_idle", busy, 0);

    // Timeout: no ack for TO cycles.
    step(1, 8'h77, 0, 0);
    for (int i = 0; i < TO; i++) step(0, 8'h00, 0, 0);
    check("to_err", timeout_err, 1);
    check("to_en", bus_enable, 0);
    step(0, 8'h00, 0, 0);
    check("to_idle", busy, 0);
    step(0, 8'h00, 0, 1);
    check("to_clr", timeout_err, 0);

    // Collision: ack on the final waiting cycle beats the timeout.
    step(1, 8'h81, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    check("coll_err", timeout_err, 0);
    step(0, 8'h00, 0, 0);

    // Set and clear of timeout_err in the same cycle: set wins.
    step(1, 8'h42, 0, 0);
    for (int i = 0; i < TO - 1; i++) step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);
    check("setclr_err", timeout_err, 1);
    step(0, 8'h00, 0, 1);

    // Stale ack in idle blocks the load; accept after it drops.
    step(1, 8'h11, 1, 0);
    check("stale_noload", busy, 0);
    step(1, 8'h22, 0, 0);
    check("stale_accept", Unsync_bus, 8'h22);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Asynchronous reset mid-request.
    step(1, 8'h5A, 0, 0);
    step(0, 8'h00, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_en", bus_enable, 0);
    check("arst_bus", Unsync_bus, 0);
    check("arst_busy", busy, 0);
    model_reset();
    exp_q.delete();
    prev_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1, 8'hC3, 0, 0);
    check("arst_reaccept", Unsync_bus, 8'hC3);

    // Random phase with a loosely behaved destination.
    a = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_en) a = a | ($urandom_range(0, 2) == 0);
      else      a = a & ($urandom_range(0, 2) != 0);
      step($urandom_range(0, 1), W'($urandom), a, $urandom_range(0, 7) == 0);
    end
    check("launch_count_nonzero", n_launched > 10, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
